// File: rtl/present_iter_if.sv
// present_iter_if: host <-> cipher engine handshake bundle.
// Carries the start/ready/done handshake, plaintext, key and ciphertext.
// With PRESENT_ABORT_EN defined, an extra abort request line is included.
interface present_iter_if #(
  parameter int KEY_W = 80
);
  logic             start;
  logic [63:0]      x;
  logic [KEY_W-1:0] k;
  logic             ready;
  logic             busy;
  logic             done;
  logic [63:0]      r;
`ifdef PRESENT_ABORT_EN
  logic             abort;

  modport master (output start, x, k, abort, input ready, busy, done, r);
  modport slave  (input start, x, k, abort, output ready, busy, done, r);
`else
  modport master (output start, x, k, input ready, busy, done, r);
  modport slave  (input start, x, k, output ready, busy, done, r);
`endif
endinterface

// File: rtl/present_iter.sv
// present_iter: iterative PRESENT encryption, one round per clock.
// 80- or 128-bit key schedule computed on the fly, ROUNDS rounds followed
// by final key whitening. Optional abort input enabled by PRESENT_ABORT_EN.
module present_iter #(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 31
) (
  input logic          clk,
  input logic          rst,
  present_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [4:0] LAST_RC = 5'(ROUNDS);

  // Reject unsupported configurations at elaboration time.
  generate
    if (!(KEY_W == 80 || KEY_W == 128)) begin : g_bad_key
      $error("present_iter: KEY_W must be 80 or 128");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
      $error("present_iter: ROUNDS must be in 1..31");
    end
  endgenerate

  function automatic logic [3:0] sbox4(input logic [3:0] a);
    logic [3:0] y;
    case (a)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  state_t           state_q, state_d;
  logic [63:0]      s_q, s_d;
  logic [KEY_W-1:0] kr_q, kr_d;
  logic [4:0]       rc_q, rc_d;
  logic [63:0]      r_q, r_d;

  logic [63:0]      t_add;
  logic [63:0]      t_sub;
  logic [63:0]      t_perm;
  logic [KEY_W-1:0] kr_rot;
  logic [KEY_W-1:0] kr_next;

  // Round datapath: key addition, 16 parallel S-boxes, bit permutation.
  assign t_add = s_q ^ kr_q[KEY_W-1 -: 64];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
      assign t_sub[4*gi +: 4] = sbox4(t_add[4*gi +: 4]);
    end
    for (genvar gi = 0; gi < 63; gi++) begin : g_perm
      assign t_perm[(16*gi) % 63] = t_sub[gi];
    end
  endgenerate
  assign t_perm[63] = t_sub[63];

  // Key schedule: rotate left by 61, S-box the top nibble(s), mix in rc.
  generate
    if (KEY_W == 80) begin : g_ks80
      assign kr_rot = {kr_q[KEY_W-62:0], kr_q[KEY_W-1:KEY_W-61]};
      // 80-bit update: one S-box nibble, counter at [19:15].
      always_comb begin
        kr_next        = kr_rot;
        kr_next[79:76] = sbox4(kr_rot[79:76]);
        kr_next[19:15] = kr_rot[19:15] ^ rc_q;
      end
    end else if (KEY_W == 128) begin : g_ks128
      assign kr_rot = {kr_q[KEY_W-62:0], kr_q[KEY_W-1:KEY_W-61]};
      // 128-bit update: two S-box nibbles, counter at [66:62].
      always_comb begin
        kr_next          = kr_rot;
        kr_next[127:124] = sbox4(kr_rot[127:124]);
        kr_next[123:120] = sbox4(kr_rot[123:120]);
        kr_next[66:62]   = kr_rot[66:62] ^ rc_q;
      end
    end else begin : g_ks_none
      assign kr_rot  = '0;
      assign kr_next = '0;
    end
  endgenerate

  // State, key, counter and result registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      kr_q    <= '0;
      rc_q    <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      kr_q    <= kr_d;
      rc_q    <= rc_d;
      r_q     <= r_d;
    end
  end

  // Next-state and datapath control; everything holds unless a case overrides.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    kr_d    = kr_q;
    rc_d    = rc_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          s_d     = bus.x;
          kr_d    = bus.k;
          rc_d    = 5'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d  = t_perm;
        kr_d = kr_next;
        rc_d = rc_q + 5'd1;
        if (rc_q == LAST_RC) begin
          // Final whitening with the key produced by this last update.
          r_d     = t_perm ^ kr_next[KEY_W-1 -: 64];
          state_d = DONE;
        end
`ifdef PRESENT_ABORT_EN
        // Abort has priority over the final round: drop the work, keep r.
        if (bus.abort) begin
          s_d     = '0;
          kr_d    = '0;
          rc_d    = '0;
          r_d     = r_q;
          state_d = IDLE;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.r     = r_q;

endmodule

// File: tb/tb_present_iter.sv
// tb_present_iter: known-answer table, handshake sequences and random
// blocks checked against an algorithmic PRESENT model (80- and 128-bit keys).
module tb_present_iter;

  localparam int ROUNDS = 31;
  localparam int SBOX_TAB [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  present_iter_if #(.KEY_W(80))  bus80 ();
  present_iter_if #(.KEY_W(128)) bus128 ();

  present_iter #(.KEY_W(80), .ROUNDS(ROUNDS)) u_dut80 (
    .clk (clk),
    .rst (rst),
    .bus (bus80)
  );

  present_iter #(.KEY_W(128), .ROUNDS(ROUNDS)) u_dut128 (
    .clk (clk),
    .rst (rst),
    .bus (bus128)
  );

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    string        name;
    int           kw;
    logic [63:0]  x;
    logic [127:0] k;
    logic [63:0]  exp;
  } vec_t;

  vec_t tab [5];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model: textbook PRESENT ----------------
  function automatic logic [127:0] key_update(input logic [127:0] kin, input int kw, input int rnd);
    logic [127:0] mask;
    logic [127:0] kk;
    logic [3:0]   n;
    mask = (kw == 80) ? {48'h0, {80{1'b1}}} : {128{1'b1}};
    kk = ((kin << 61) | (kin >> (kw - 61))) & mask;
    n  = 4'(kk >> (kw - 4));
    kk = (kk & ~(128'hF << (kw - 4))) | (128'(SBOX_TAB[n]) << (kw - 4));
    if (kw == 128) begin
      n  = 4'(kk >> (kw - 8));
      kk = (kk & ~(128'hF << (kw - 8))) | (128'(SBOX_TAB[n]) << (kw - 8));
    end
    kk = kk ^ (128'(rnd) << ((kw == 80) ? 15 : 62));
    return kk;
  endfunction

  function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [127:0] key, input int kw);
    logic [127:0] kk;
    logic [63:0]  st;
    logic [63:0]  tmp;
    kk = key;
    st = pt;
    for (int rnd = 1; rnd <= ROUNDS; rnd++) begin
      st = st ^ 64'(kk >> (kw - 64));
      for (int n = 0; n < 16; n++) st[4*n +: 4] = 4'(SBOX_TAB[st[4*n +: 4]]);
      tmp = st;
      for (int i = 0; i < 64; i++) st[(i == 63) ? 63 : (16 * i) % 63] = tmp[i];
      kk = key_update(kk, kw, rnd);
    end
    return st ^ 64'(kk >> (kw - 64));
  endfunction

  // ---------------- single-block drivers ----------------
  // lat = number of rising edges after the accepting edge until done is seen.
  task automatic op80(input logic [63:0] xv, input logic [79:0] kv, output logic [63:0] rv, output int lat);
    @(negedge clk);
    bus80.start = 1'b1; bus80.x = xv; bus80.k = kv;
    @(posedge clk); #1;
    bus80.start = 1'b0;
    bus80.x = {$urandom(), $urandom()};
    bus80.k = 80'({$urandom(), $urandom(), $urandom()});
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!bus80.done && lat < 100);
    rv = bus80.r;
  endtask

  task automatic op128(input logic [63:0] xv, input logic [127:0] kv, output logic [63:0] rv, output int lat);
    @(negedge clk);
    bus128.start = 1'b1; bus128.x = xv; bus128.k = kv;
    @(posedge clk); #1;
    bus128.start = 1'b0;
    bus128.x = {$urandom(), $urandom()};
    bus128.k = {$urandom(), $urandom(), $urandom(), $urandom()};
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!bus128.done && lat < 100);
    rv = bus128.r;
  endtask

  initial begin
    logic [63:0]  rv;
    logic [63:0]  last80;
    logic [63:0]  xv;
    logic [79:0]  kv80;
    logic [127:0] kv128;
    logic [63:0]  exp_q [$];
    int lat, idx, cyc, last_done, ndone, nbusy;

    tab[0] = '{"zero80",   80,  64'h0,                 128'h0,                                  64'h5579C1387B228445};
    tab[1] = '{"keyones",  80,  64'h0,                 {48'h0, 80'hFFFFFFFFFFFFFFFFFFFF},       64'hE72C46C0F5945049};
    tab[2] = '{"ptones",   80,  64'hFFFFFFFFFFFFFFFF,  128'h0,                                  64'hA112FFC72F68417B};
    tab[3] = '{"allones",  80,  64'hFFFFFFFFFFFFFFFF,  {48'h0, 80'hFFFFFFFFFFFFFFFFFFFF},       64'h3333DCD3213210D2};
    tab[4] = '{"zero128",  128, 64'h0,                 128'h0,                                  64'h96DB702A2E6900AF};

    rst = 1'b1;
    bus80.start = 1'b0;  bus80.x = '0;  bus80.k = '0;
    bus128.start = 1'b0; bus128.x = '0; bus128.k = '0;
`ifdef PRESENT_ABORT_EN
    bus80.abort = 1'b0;  bus128.abort = 1'b0;
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset ready", 128'(bus80.ready), 128'(1));
    check("reset busy",  128'(bus80.busy),  128'(0));
    check("reset done",  128'(bus80.done),  128'(0));
    check("reset r",     128'(bus80.r),     128'(0));
    check("reset r128",  128'(bus128.r),    128'(0));
    rst = 1'b0;

    // Known-answer table; done is seen after ROUNDS edges (cycle ROUNDS+1).
    for (int i = 0; i < 5; i++) begin
      if (tab[i].kw == 80) op80(tab[i].x, tab[i].k[79:0], rv, lat);
      else                 op128(tab[i].x, tab[i].k, rv, lat);
      $display("vec %s r=%h lat=%0d", tab[i].name, rv, lat);
      check($sformatf("%s r", tab[i].name), 128'(rv), 128'(tab[i].exp));
      check($sformatf("%s latency", tab[i].name), 128'(lat), 128'(ROUNDS));
      @(negedge clk);
      check($sformatf("%s ready after", tab[i].name),
            128'((tab[i].kw == 80) ? bus80.ready : bus128.ready), 128'(1));
      check($sformatf("%s done pulse", tab[i].name),
            128'((tab[i].kw == 80) ? bus80.done : bus128.done), 128'(0));
    end

    // Back-to-back with start held high: ROUNDS+2 cycles between done pulses.
    idx = 0; cyc = 0; last_done = -1; ndone = 0;
    while (ndone < 4 && cyc < 400) begin
      @(negedge clk); cyc++;
      if (bus80.done) begin
        check($sformatf("b2b r%0d", ndone), 128'(bus80.r), 128'(exp_q.pop_front()));
        if (last_done >= 0) check($sformatf("b2b gap%0d", ndone), 128'(cyc - last_done), 128'(ROUNDS + 2));
        $display("b2b block %0d r=%h cycle=%0d", ndone, bus80.r, cyc);
        last_done = cyc;
        ndone++;
      end
      if (bus80.ready && idx < 4) begin
        bus80.start = 1'b1;
        bus80.x = tab[idx].x;
        bus80.k = tab[idx].k[79:0];
        exp_q.push_back(tab[idx].exp);
        idx++;
      end
    end
    bus80.start = 1'b0;
    check("b2b count", 128'(ndone), 128'(4));

    // Inputs toggling during RUN while start stays high.
    @(negedge clk);
    bus80.start = 1'b1; bus80.x = '0; bus80.k = '0;
    @(posedge clk); #1;
    nbusy = 0; ndone = 0; cyc = 0;
    rv = '0;
    while (ndone == 0 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (bus80.busy) nbusy++;
      if (bus80.done) begin
        ndone++;
        rv = bus80.r;
        bus80.start = 1'b0;
      end else begin
        bus80.x = {$urandom(), $urandom()};
        bus80.k = 80'({$urandom(), $urandom(), $urandom()});
      end
    end
    @(negedge clk);
    if (bus80.done) ndone++;
    $display("toggle r=%h busy=%0d dones=%0d", rv, nbusy, ndone);
    check("toggle r", 128'(rv), 128'(64'h5579C1387B228445));
    check("toggle busy cycles", 128'(nbusy), 128'(ROUNDS));
    check("toggle done count", 128'(ndone), 128'(1));
    check("toggle r held", 128'(bus80.r), 128'(64'h5579C1387B228445));

    // Asynchronous reset during round 10.
    @(negedge clk);
    bus80.start = 1'b1; bus80.x = '0; bus80.k = '0;
    @(posedge clk); #1;
    bus80.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    $display("midrun reset ready=%0b busy=%0b done=%0b r=%h", bus80.ready, bus80.busy, bus80.done, bus80.r);
    check("midrst r",     128'(bus80.r),     128'(0));
    check("midrst ready", 128'(bus80.ready), 128'(1));
    check("midrst busy",  128'(bus80.busy),  128'(0));
    check("midrst done",  128'(bus80.done),  128'(0));
    @(negedge clk);
    rst = 1'b0;
    op80(64'h0, 80'h0, rv, lat);
    $display("after reset r=%h lat=%0d", rv, lat);
    check("postrst r", 128'(rv), 128'(64'h5579C1387B228445));

    // Random blocks against the model.
    for (int i = 0; i < 8; i++) begin
      xv   = {$urandom(), $urandom()};
      kv80 = 80'({$urandom(), $urandom(), $urandom()});
      op80(xv, kv80, rv, lat);
      $display("rand80 x=%h k=%h r=%h", xv, kv80, rv);
      check($sformatf("rand80 %0d", i), 128'(rv), 128'(ref_enc(xv, 128'(kv80), 80)));
      last80 = rv;
    end
    for (int i = 0; i < 4; i++) begin
      xv    = {$urandom(), $urandom()};
      kv128 = {$urandom(), $urandom(), $urandom(), $urandom()};
      op128(xv, kv128, rv, lat);
      $display("rand128 x=%h k=%h r=%h", xv, kv128, rv);
      check($sformatf("rand128 %0d", i), 128'(rv), 128'(ref_enc(xv, kv128, 128)));
    end

`ifdef PRESENT_ABORT_EN
    // Abort during round 5.
    @(negedge clk);
    bus80.start = 1'b1; bus80.x = '0; bus80.k = '0;
    @(posedge clk); #1;
    bus80.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus80.abort = 1'b1;
    @(posedge clk); #1;
    bus80.abort = 1'b0;
    @(negedge clk);
    $display("abort r5 ready=%0b done=%0b r=%h", bus80.ready, bus80.done, bus80.r);
    check("abort5 ready", 128'(bus80.ready), 128'(1));
    check("abort5 busy",  128'(bus80.busy),  128'(0));
    check("abort5 r",     128'(bus80.r),     128'(last80));
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus80.done) ndone++;
    end
    check("abort5 no done", 128'(ndone), 128'(0));

    // Abort coinciding with the final round edge.
    @(negedge clk);
    bus80.start = 1'b1; bus80.x = '0; bus80.k = '0;
    @(posedge clk); #1;
    bus80.start = 1'b0;
    repeat (ROUNDS - 1) @(posedge clk);
    @(negedge clk);
    bus80.abort = 1'b1;
    @(posedge clk); #1;
    bus80.abort = 1'b0;
    @(negedge clk);
    $display("abort final ready=%0b done=%0b r=%h", bus80.ready, bus80.done, bus80.r);
    check("abortfin done",  128'(bus80.done),  128'(0));
    check("abortfin ready", 128'(bus80.ready), 128'(1));
    check("abortfin r",     128'(bus80.r),     128'(last80));
    op80(64'h0, 80'h0, rv, lat);
    check("post abort r", 128'(rv), 128'(64'h5579C1387B228445));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
